gate2_exhaustive_checker: RTL

- Self-contained sequential stimulus/response stage for any 2-input combinational gate (default: NAND).
- Drives a and b of the gate under test through all four input vectors in order 00, 01, 10, 11, holding each for a fixed number of cycles.
- Samples the gate's y at the end of each hold window and compares it against a parameterised truth table.
- Reports pass/fail, a mismatch count and a per-vector failure mask.
- Sits directly upstream of the gate (feeds a/b) and directly downstream of it (consumes y). Replaces hand-timed stimulus with a clocked, checkable stage.

---
 rtl/gate2_exhaustive_checker.sv | 106 ++++++++++
 1 files changed

// File: rtl/gate2_exhaustive_checker.sv
// Sweeps a 2-input gate through {a,b} = 00,01,10,11, holding each vector HOLD_CYCLES cycles,
// and checks y on the last cycle of each window against TRUTH[{a,b}]; done 4*HOLD_CYCLES after start.
module gate2_exhaustive_checker #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [3:0]  TRUTH       = 4'b0111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [1:0] ab_q, ab_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;
  logic       pass_q, pass_d;
  logic       mism;

  // X/Z on y must count as a failure, hence the case inequality.
  assign mism = (y !== TRUTH[vec_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      ab_q    <= 2'd0;
      cnt_q   <= 8'd0;
      err_q   <= 3'd0;
      mask_q  <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      ab_q    <= ab_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ab_d    = ab_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HOLD;
          vec_d   = 2'd0;
          ab_d    = 2'd0;
          cnt_d   = 8'd0;
          err_d   = 3'd0;
          mask_d  = 4'd0;
          pass_d  = 1'b0;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST) begin
          if (mism) begin
            err_d         = err_q + 3'd1;
            mask_d[vec_q] = 1'b1;
          end
          cnt_d = 8'd0;
          if (vec_q == 2'd3) begin
            state_d = DONE;
            pass_d  = (err_q == 3'd0) && !mism;
            ab_d    = 2'd0;
          end else begin
            vec_d = vec_q + 2'd1;
            ab_d  = vec_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = (state_q == HOLD);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule
